// File: rtl/branch_unit_if.sv
// Identify-stage to branch-unit bundle: branch presentation, SPR write path and
// the registered result/SPR views returned to the core.
interface branch_unit_if;
  logic        i_en;
  logic [0:31] i_instr;
  logic        i_i_form;
  logic        i_b_form;
  logic        i_cond_LR;
  logic        i_cond_CTR;
  logic        i_cond_TAR;
  logic [0:63] i_cia;
  logic [0:31] i_cr;
  logic        i_spr_we;
  logic [1:0]  i_spr_sel;
  logic [0:63] i_spr_wdata;
  logic        o_valid;
  logic        o_taken;
  logic [0:63] o_nia;
  logic        o_illegal;
  logic [0:63] o_lr;
  logic [0:63] o_ctr;
  logic [0:63] o_tar;

  modport master (
    output i_en, i_instr, i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR,
           i_cia, i_cr, i_spr_we, i_spr_sel, i_spr_wdata,
    input  o_valid, o_taken, o_nia, o_illegal, o_lr, o_ctr, o_tar
  );

  modport slave (
    input  i_en, i_instr, i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR,
           i_cia, i_cr, i_spr_we, i_spr_sel, i_spr_wdata,
    output o_valid, o_taken, o_nia, o_illegal, o_lr, o_ctr, o_tar
  );
endinterface

// File: rtl/branch_unit.sv
// Branch execution unit: resolves I/B/XL-form branches, owns LR/CTR/TAR and
// returns a registered redirect one cycle after acceptance.
module branch_unit (
  input logic          i_clk,
  input logic          i_rst,
  branch_unit_if.slave bru
);

  logic [0:63] lr_q, ctr_q, tar_q;
  logic [0:63] nia_q;
  logic        valid_q, illegal_q, taken_q;

  logic [0:4]  bo;
  logic [4:0]  bi;
  logic [23:0] li;
  logic [13:0] bd;
  logic        aa, lk;
  logic        is_bcctr;
  logic        illegal;
  logic        dec_ctr;
  logic [0:63] ctr_m;
  logic        ctr_ok, cond_ok, taken;
  logic [0:63] cia_p4;
  logic [0:63] exts_li, exts_bd;
  logic [0:63] target;

  always_comb begin
    bo       = bru.i_instr[6:10];
    bi       = bru.i_instr[11:15];
    li       = bru.i_instr[6:29];
    bd       = bru.i_instr[16:29];
    aa       = bru.i_instr[30];
    lk       = bru.i_instr[31];
    is_bcctr = bru.i_cond_CTR;
    illegal  = !$onehot({bru.i_i_form, bru.i_b_form, bru.i_cond_LR,
                         bru.i_cond_CTR, bru.i_cond_TAR})
               || (is_bcctr && !bo[2]);
    cia_p4   = bru.i_cia + 64'd4;
    exts_li  = {{38{li[23]}}, li, 2'b00};
    exts_bd  = {{48{bd[13]}}, bd, 2'b00};
    ctr_m    = ctr_q - 64'd1;
    // bcctr branches through CTR itself, so it never counts it down
    dec_ctr  = !bo[2] && !is_bcctr && !bru.i_i_form;
    ctr_ok   = is_bcctr || bo[2] || ((ctr_m != 64'd0) ^ bo[3]);
    cond_ok  = bo[0] || (bru.i_cr[bi] == bo[1]);
    taken    = bru.i_i_form || (ctr_ok && cond_ok);

    target = '0;
    if (bru.i_i_form)
      target = aa ? exts_li : (bru.i_cia + exts_li);
    else if (bru.i_b_form)
      target = aa ? exts_bd : (bru.i_cia + exts_bd);
    else if (bru.i_cond_LR)
      target = {lr_q[0:61], 2'b00};
    else if (bru.i_cond_CTR)
      target = {ctr_q[0:61], 2'b00};
    else
      target = {tar_q[0:61], 2'b00};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
      nia_q     <= '0;
      lr_q      <= '0;
      ctr_q     <= '0;
      tar_q     <= '0;
    end else begin
      valid_q   <= bru.i_en && !illegal;
      illegal_q <= bru.i_en && illegal;

      if (bru.i_spr_we) begin
        case (bru.i_spr_sel)
          2'd0:    lr_q  <= bru.i_spr_wdata;
          2'd1:    ctr_q <= bru.i_spr_wdata;
          2'd2:    tar_q <= bru.i_spr_wdata;
          default: ;
        endcase
      end

      // Branch updates come last so they override an mtspr to the same SPR
      if (bru.i_en && !illegal) begin
        taken_q <= taken;
        nia_q   <= taken ? target : cia_p4;
        if (lk)
          lr_q <= cia_p4;
        if (dec_ctr)
          ctr_q <= ctr_m;
      end
    end
  end

  assign bru.o_valid   = valid_q;
  assign bru.o_illegal = illegal_q;
  assign bru.o_taken   = taken_q;
  assign bru.o_nia     = nia_q;
  assign bru.o_lr      = lr_q;
  assign bru.o_ctr     = ctr_q;
  assign bru.o_tar     = tar_q;

endmodule

// File: tb/tb_branch_unit.sv
// Table-driven bench for branch_unit: each row is driven, its expectation queued,
// then popped and compared one cycle later, plus an async-reset sequence.
module tb_branch_unit;

  logic clk;
  logic rst;
  branch_unit_if bru ();

  branch_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bru   (bru.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  forms;   // {I, B, LR, CTR, TAR}
    logic [31:0] instr;
    logic [63:0] cia;
    logic [31:0] cr;
    logic        spr_we;
    logic [1:0]  spr_sel;
    logic [63:0] spr_wdata;
    logic        e_valid;
    logic        e_ill;
    logic        chk_res;
    logic        e_taken;
    logic [63:0] e_nia;
    logic [63:0] e_lr;
    logic [63:0] e_ctr;
    logic [63:0] e_tar;
  } vec_t;

  localparam logic [4:0] F_I   = 5'b10000;
  localparam logic [4:0] F_B   = 5'b01000;
  localparam logic [4:0] F_LR  = 5'b00100;
  localparam logic [4:0] F_CTR = 5'b00010;
  localparam logic [4:0] F_TAR = 5'b00001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vt[16];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bru.i_en        = v.en;
    {bru.i_i_form, bru.i_b_form, bru.i_cond_LR, bru.i_cond_CTR, bru.i_cond_TAR} = v.forms;
    bru.i_instr     = v.instr;
    bru.i_cia       = v.cia;
    bru.i_cr        = v.cr;
    bru.i_spr_we    = v.spr_we;
    bru.i_spr_sel   = v.spr_sel;
    bru.i_spr_wdata = v.spr_wdata;
  endtask

  task automatic check_row(input int idx, input vec_t e);
    chk($sformatf("row%0d valid", idx),   {63'd0, bru.o_valid},   {63'd0, e.e_valid});
    chk($sformatf("row%0d illegal", idx), {63'd0, bru.o_illegal}, {63'd0, e.e_ill});
    if (e.chk_res) begin
      chk($sformatf("row%0d taken", idx), {63'd0, bru.o_taken}, {63'd0, e.e_taken});
      chk($sformatf("row%0d nia", idx),   bru.o_nia, e.e_nia);
    end
    chk($sformatf("row%0d lr", idx),  bru.o_lr,  e.e_lr);
    chk($sformatf("row%0d ctr", idx), bru.o_ctr, e.e_ctr);
    chk($sformatf("row%0d tar", idx), bru.o_tar, e.e_tar);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"},   {63'd0, bru.o_valid},   64'd0);
    chk({tag, " illegal"}, {63'd0, bru.o_illegal}, 64'd0);
    chk({tag, " taken"},   {63'd0, bru.o_taken},   64'd0);
    chk({tag, " nia"},     bru.o_nia, 64'd0);
    chk({tag, " lr"},      bru.o_lr,  64'd0);
    chk({tag, " ctr"},     bru.o_ctr, 64'd0);
    chk({tag, " tar"},     bru.o_tar, 64'd0);
  endtask

  vec_t idle;

  initial begin
    //        en forms        instr         cia     cr            we sel wdata         v  il cr tk nia            lr            ctr            tar
    vt[0]  = '{1, F_I,        32'h48032BFB, 64'h1000, 32'h0,        0, 0, 64'h0,        1, 0, 1, 1, 64'h32BF8,    64'h1004,     64'h0,  64'h0};
    vt[1]  = '{0, 5'b0,       32'h0,        64'h0,    32'h0,        1, 1, 64'h2,        0, 0, 1, 1, 64'h32BF8,    64'h1004,     64'h2,  64'h0};
    vt[2]  = '{1, F_B,        32'h4200FFF8, 64'h2000, 32'h0,        0, 0, 64'h0,        1, 0, 1, 1, 64'h1FF8,     64'h1004,     64'h1,  64'h0};
    vt[3]  = '{1, F_B,        32'h4200FFF8, 64'h2004, 32'h0,        0, 0, 64'h0,        1, 0, 1, 0, 64'h2008,     64'h1004,     64'h0,  64'h0};
    vt[4]  = '{1, F_B,        32'h4200FFF8, 64'h3000, 32'h0,        0, 0, 64'h0,        1, 0, 1, 1, 64'h2FF8,     64'h1004,     ONES,   64'h0};
    vt[5]  = '{0, 5'b0,       32'h0,        64'h0,    32'h0,        1, 0, 64'h40000003, 0, 0, 1, 1, 64'h2FF8,     64'h40000003, ONES,   64'h0};
    vt[6]  = '{1, F_LR,       32'h4E800021, 64'h3000, 32'h0,        1, 0, 64'h55,       1, 0, 1, 1, 64'h40000000, 64'h3004,     ONES,   64'h0};
    vt[7]  = '{1, F_CTR,      32'h4E000420, 64'h3100, 32'h0,        0, 0, 64'h0,        0, 1, 0, 0, 64'h0,        64'h3004,     ONES,   64'h0};
    vt[8]  = '{1, F_I | F_B,  32'h48000000, 64'h3200, 32'h0,        0, 0, 64'h0,        0, 1, 0, 0, 64'h0,        64'h3004,     ONES,   64'h0};
    vt[9]  = '{0, 5'b0,       32'h0,        64'h0,    32'h0,        1, 2, 64'h1234567B, 0, 0, 0, 0, 64'h0,        64'h3004,     ONES,   64'h1234567B};
    vt[10] = '{1, F_TAR,      32'h4E800460, 64'h5000, 32'h0,        1, 1, 64'h77,       1, 0, 1, 1, 64'h12345678, 64'h3004,     64'h77, 64'h1234567B};
    vt[11] = '{1, F_I,        32'h4BFFFFF0, 64'h8000, 32'h0,        0, 0, 64'h0,        1, 0, 1, 1, 64'h7FF0,     64'h3004,     64'h77, 64'h1234567B};
    vt[12] = '{0, 5'b0,       32'h0,        64'h0,    32'h0,        1, 3, 64'h99,       0, 0, 1, 1, 64'h7FF0,     64'h3004,     64'h77, 64'h1234567B};
    vt[13] = '{1, F_B,        32'h41820010, 64'h6000, 32'h0,        0, 0, 64'h0,        1, 0, 1, 0, 64'h6004,     64'h3004,     64'h77, 64'h1234567B};
    vt[14] = '{1, F_B,        32'h41820010, 64'h6000, 32'h20000000, 0, 0, 64'h0,        1, 0, 1, 1, 64'h6010,     64'h3004,     64'h77, 64'h1234567B};
    vt[15] = '{0, 5'b0,       32'h0,        64'h0,    32'h0,        0, 0, 64'h0,        0, 0, 1, 0, 64'h0,        64'h0,        64'h0,  64'h0};

    idle = vt[15];
    drive(idle);
    rst = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // rows 0..14 run back-to-back; the expectation is checked after the next edge
    for (int i = 0; i < 15; i++) begin
      vec_t e;
      drive(vt[i]);
      sb.push_back(vt[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_row(i, e);
    end

    // async reset right after the taken beq acceptance: outputs drop before any edge
    drive(idle);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // idle cycle after reset: nothing moves, pulses stay low
    drive(vt[15]);
    sb.push_back(vt[15]);
    @(posedge clk);
    #1;
    begin
      vec_t e;
      e = sb.pop_front();
      check_row(15, e);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch execution unit (BRU) for the core. It consumes the instruction and form flags that the identify stage forwards on its BRU interface, then resolves I-form, B-form and XL-form (bclr/bcctr/bctar) branches. It owns the LR, CTR and TAR registers and produces a registered redirect (next instruction address) for fetch one cycle after acceptance.

## Interface
Parameters:
- none; addresses, LR, CTR and TAR are 64-bit, CR is 32-bit.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_en  in  1  a branch instruction is presented this cycle.
- i_instr  in  [0:31]  instruction word, big-endian bit numbering.
- i_i_form  in  1  I-form (b/ba/bl/bla).
- i_b_form  in  1  B-form (bc family).
- i_cond_LR  in  1  XL-form bclr.
- i_cond_CTR  in  1  XL-form bcctr.
- i_cond_TAR  in  1  XL-form bctar.
- i_cia  in  [0:63]  address of the presented instruction.
- i_cr  in  [0:31]  condition register, sampled at acceptance.
- i_spr_we  in  1  SPR write strobe (mtspr path).
- i_spr_sel  in  [1:0]  target SPR: 0 = LR, 1 = CTR, 2 = TAR, 3 = ignored.
- i_spr_wdata  in  [0:63]  SPR write data.
- o_valid  out  1  one-cycle pulse; result of the last accepted branch.
- o_taken  out  1  branch taken.
- o_nia  out  [0:63]  next instruction address (target if taken, else CIA+4).
- o_illegal  out  1  one-cycle pulse; the instruction was rejected.
- o_lr, o_ctr, o_tar  out  [0:63] each  current SPR values.

## Operation
- Acceptance: at a rising i_clk edge with i_en=1. Exactly one form flag must be set. If zero or several flags are set, or the instruction is bcctr with BO[2]=0: o_illegal pulses, o_valid stays 0, and no SPR changes.
- Fields: BO=instr[6:10], BI=instr[11:15], LI=instr[6:29], BD=instr[16:29], AA=instr[30], LK=instr[31].
- I-form: always taken. The target is EXTS(LI||0b00) if AA=1, otherwise CIA + EXTS(LI||0b00). Arithmetic is modulo 2^64.
- B-form target: EXTS(BD||0b00), relative to CIA unless AA=1.
- XL-form target: bclr uses LR[0:61]||0b00, bcctr uses CTR[0:61]||0b00, bctar uses TAR[0:61]||0b00. AA is ignored.
- CTR handling (B-form, bclr, bctar): if BO[2]=0, CTR_M = CTR−1 (0 wraps to all-ones) and CTR is written with CTR_M.
- ctr_ok = BO[2] | ((CTR_M≠0) ^ BO[3]).
- cond_ok = BO[0] | (i_cr[BI] == BO[1]).
- Taken = ctr_ok & cond_ok. bcctr never decrements CTR, so its ctr_ok is 1.
- LK=1: LR ← CIA+4 whether or not the branch is taken. Target computation uses the pre-update LR and CTR (bclrl jumps to the old LR).
- SPR writes: i_spr_we writes the selected SPR at the edge. If a branch updates the same SPR in the same cycle, the branch update wins. Writes to different SPRs both take effect.
- Not taken: o_nia = CIA+4.

## Timing
- Reset: o_valid, o_taken and o_illegal = 0; o_nia = 0; LR, CTR and TAR = 0. Reset applies immediately, asynchronously.
- Latency is 1: inputs are sampled at edge N. o_valid/o_illegal, o_taken, o_nia and the SPR updates become visible after edge N.
- o_valid and o_illegal are single-cycle pulses. o_taken and o_nia hold until the next acceptance.
- Back-to-back branches on consecutive cycles are supported. The second branch sees the SPR values written by the first (no stall, no bypass needed).
- o_lr, o_ctr and o_tar are register outputs. A value written at edge N is readable after N.
- Reset asserted while o_valid is high: all outputs drop to reset values immediately, and the pending result is lost.
- i_en=0: no state change; pulses deassert.

## Test plan
- Reset, then I-form 0x48032BFB (LI=0x00CAFE, AA=1, LK=1) with CIA=0x1000 -> o_valid=1, o_taken=1, o_nia=0x0000_0000_0003_2BF8, o_lr=0x1004.
- bdnz 0x4200FFF8 (BO=16, BD=−8) with CIA=0x2000, CTR preloaded to 2 via SPR write. First issue -> taken, o_nia=0x1FF8, o_ctr=1. Second issue, back-to-back -> not taken, o_nia=0x2008 (CIA+4 of second, CIA=0x2004), o_ctr=0.
- CTR=0 with bdnz -> CTR wraps to 0xFFFF_FFFF_FFFF_FFFF, taken.
- LR=0x4000_0003, bclrl 0x4E800021 with CIA=0x3000 -> o_nia=0x4000_0000, o_lr=0x3004. In the same cycle, an SPR write to LR of 0x55 -> o_lr=0x3004 (branch wins).
- bcctr 0x4E000420 (BO[2]=0) -> o_illegal pulse, o_valid=0, CTR/LR unchanged. i_en with both i_i_form and i_b_form set -> o_illegal.
- Conditional 0x41820010 (beq +16, BO=12, BI=2) with i_cr[2]=0 -> not taken, o_nia=CIA+4. Repeat with i_cr[2]=1 -> taken, o_nia=CIA+16. Assert i_rst right after that acceptance -> all outputs 0 at once.
